// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the I-cache request, registers the fetched word
// for decode, and handles miss stalls, branch/iret redirects and I-TLB misses.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_1000,
  parameter logic [31:0] EXC_PC    = 32'h0000_2000,
  parameter logic [31:0] NOP_INSTR = 32'hFC00_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_fetch,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        iret,
  input  logic        tlb_miss_instr,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_ready,
  input  logic [31:0] icache_data,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        valid_out,
  output logic        block_pipe_instr_cache,
  output logic [31:0] epc,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {FETCH = 2'd0, WAIT = 2'd1, HOLD = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] tgt_q, tgt_d;
  logic        valid_q, valid_d;
  logic        pend_q, pend_d;
  logic        tlb_q;
  logic        live_q;

  logic        tlb_rise;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        accept;
  logic [31:0] accept_word;

  // Redirects take priority over every state action; accept and redirect never coincide.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc_out_d    = pc_out_q;
    epc_d       = epc_q;
    buf_d       = buf_q;
    tgt_d       = tgt_q;
    valid_d     = valid_q;
    pend_d      = pend_q;
    tlb_rise    = tlb_miss_instr & ~tlb_q;
    redirect    = 1'b0;
    redirect_pc = pc_q;
    accept      = 1'b0;
    accept_word = icache_data;

    if (tlb_rise) begin
      redirect    = 1'b1;
      redirect_pc = EXC_PC;
      epc_d       = pc_q;
    end else if (iret) begin
      redirect    = 1'b1;
      redirect_pc = epc_q;
    end else if (branch_taken && state_q != WAIT) begin
      redirect    = 1'b1;
      redirect_pc = branch_target;
    end else begin
      case (state_q)
        FETCH: begin
          if (live_q && en_fetch) begin
            if (icache_ready) begin
              accept = 1'b1;
            end else begin
              state_d = WAIT;
              instr_d = NOP_INSTR;
              valid_d = 1'b0;
            end
          end
        end
        WAIT: begin
          // A branch during a miss is remembered; the in-flight word is thrown away.
          if (branch_taken) begin
            pend_d = 1'b1;
            tgt_d  = branch_target;
          end
          if (icache_ready) begin
            if (branch_taken) begin
              redirect    = 1'b1;
              redirect_pc = branch_target;
            end else if (pend_q) begin
              redirect    = 1'b1;
              redirect_pc = tgt_q;
            end else if (en_fetch) begin
              accept = 1'b1;
            end else begin
              buf_d   = icache_data;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (en_fetch) begin
            accept      = 1'b1;
            accept_word = buf_q;
          end
        end
        default: state_d = FETCH;
      endcase
    end

    if (redirect) begin
      pc_d    = redirect_pc;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      state_d = FETCH;
      pend_d  = 1'b0;
      buf_d   = '0;
    end
    if (accept) begin
      instr_d  = accept_word;
      pc_out_d = pc_q;
      valid_d  = 1'b1;
      pc_d     = pc_q + 32'd4;
      state_d  = FETCH;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      pc_out_q <= '0;
      epc_q    <= '0;
      buf_q    <= '0;
      tgt_q    <= '0;
      valid_q  <= 1'b0;
      pend_q   <= 1'b0;
      tlb_q    <= 1'b0;
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      epc_q    <= epc_d;
      buf_q    <= buf_d;
      tgt_q    <= tgt_d;
      valid_q  <= valid_d;
      pend_q   <= pend_d;
      tlb_q    <= tlb_miss_instr;
      live_q   <= 1'b1;
    end
  end

  // live_q keeps the request low until the first edge after reset release.
  assign icache_req             = live_q && (state_q != HOLD);
  assign icache_addr            = pc_q;
  assign block_pipe_instr_cache = (state_q == WAIT);
  assign instruction            = instr_q;
  assign pc_out                 = pc_out_q;
  assign valid_out              = valid_q;
  assign epc                    = epc_q;
  assign dbg_state_o            = state_q;

endmodule
